// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch and
// data (lw/sw) requesters. Data has priority, but after DBURST consecutive
// data grants while fetch waits, fetch is served. Every access has a bounded
// latency of TIMEOUT cycles, after which it is aborted with err.
//
// Handshake: a requester raises x_req with stable address/data and holds it
// until the one-cycle x_done pulse. The memory side sees mem_req held high
// with stable mem_* fields until a one-cycle mem_ack, or until the arbiter
// aborts on timeout. mem_ack while mem_req is low is ignored.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int DBURST  = 4,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    output logic              if_stall,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_done,
    output logic              d_stall,
    output logic              err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [1:0]        dbg_state
);

    localparam int BW = $clog2(DBURST + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [BW-1:0] BURST_MAX = BW'(DBURST);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BUSY_I = 2'd1,
        S_BUSY_D = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [BW-1:0]     burst_q, burst_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              if_done_q, if_done_d;
    logic              d_done_q, d_done_d;
    logic              err_q, err_d;

    logic              grant_d;
    logic              grant_i;
    logic              busy;
    logic              timed_out;
    logic [DATA_W-1:0] ack_data;

    // Arbitration: data wins unless fetch is waiting and the data burst is used up.
    assign grant_d   = (state_q == S_IDLE) && d_req && (!if_req || (burst_q != BURST_MAX));
    assign grant_i   = (state_q == S_IDLE) && !grant_d && if_req;
    assign busy      = (state_q == S_BUSY_I) || (state_q == S_BUSY_D);
    // The last allowed cycle of an access; an ack in this same cycle still wins.
    assign timed_out = busy && !mem_ack && (tmo_q == TMO_LAST);
    // Stores return zero rather than whatever the bus happens to carry.
    assign ack_data  = mem_we_q ? '0 : mem_rdata;

    // State and datapath registers, synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            burst_q     <= '0;
            tmo_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            if_done_q   <= 1'b0;
            d_done_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            burst_q     <= burst_d;
            tmo_q       <= tmo_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            if_done_q   <= if_done_d;
            d_done_q    <= d_done_d;
            err_q       <= err_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (grant_d)      state_d = S_BUSY_D;
                else if (grant_i) state_d = S_BUSY_I;
            end
            S_BUSY_I, S_BUSY_D: begin
                if (mem_ack || timed_out) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Registered outputs, burst counter and timeout counter for the next cycle.
    always_comb begin
        burst_d     = burst_q;
        tmo_d       = tmo_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        if_done_d   = 1'b0;
        d_done_d    = 1'b0;
        err_d       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!if_req) begin
                    burst_d = '0;
                end else if (grant_d) begin
                    burst_d = (burst_q == BURST_MAX) ? burst_q : burst_q + BW'(1);
                end else begin
                    burst_d = '0;
                end
                if (grant_d) begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = d_we;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    tmo_d       = '0;
                end else if (grant_i) begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = if_addr;
                    mem_wdata_d = '0;
                    tmo_d       = '0;
                end
            end
            S_BUSY_I, S_BUSY_D: begin
                if (mem_ack || timed_out) begin
                    mem_req_d = 1'b0;
                    err_d     = timed_out;
                    if (state_q == S_BUSY_I) begin
                        if_done_d  = 1'b1;
                        if_rdata_d = timed_out ? '0 : ack_data;
                    end else begin
                        d_done_d  = 1'b1;
                        d_rdata_d = timed_out ? '0 : ack_data;
                    end
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            default: ;
        endcase
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign if_done   = if_done_q;
    assign d_done    = d_done_q;
    assign err       = err_q;
    assign if_stall  = if_req & ~if_done_q;
    assign d_stall   = d_req & ~d_done_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a transaction-level model predicts every
// output each cycle; directed scenarios add hand-computed literal checks.
module tb_mem_port_arbiter;
    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int DBURST  = 4;
    localparam int TIMEOUT = 15;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic [DW-1:0] if_rdata;
    logic          if_done, if_stall;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic [DW-1:0] d_rdata;
    logic          d_done, d_stall, err;
    logic          mem_req, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_ack = 1'b0;
    logic [1:0]    dbg_state;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DBURST(DBURST), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done), .if_stall(if_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata),
        .d_done(d_done), .d_stall(d_stall), .err(err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .dbg_state(dbg_state)
    );

    // Clock and cycle counter.
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory responder: acks ack_delay cycles after mem_req rises (-1 = never).
    int            ack_delay = 1;
    logic [DW-1:0] ack_data  = '0;
    logic          force_ack = 1'b0;
    int            req_age   = 0;
    always @(posedge clk) begin
        #2;
        if (mem_req) req_age = req_age + 1;
        else         req_age = 0;
        mem_ack   = force_ack || (mem_req && ack_delay >= 0 && req_age == ack_delay + 1);
        mem_rdata = ack_data;
    end

    // Model state: expected outputs for the current cycle plus the port's occupancy.
    logic          e_mem_req = 0, e_we = 0, e_if_done = 0, e_d_done = 0, e_err = 0;
    logic [AW-1:0] e_addr = '0;
    logic [DW-1:0] e_wdata = '0, e_if_rdata = '0, e_d_rdata = '0, m_rd;
    bit            m_busy = 0, m_gap = 0, m_owner_d = 0;
    int            m_age = 0, m_burst = 0;
    byte           dut_log[$];
    byte           mdl_log[$];
    bit            prev_req = 0;
    int            req_high_cnt = 0;
    bit            seen_valid = 0;
    logic          seen_we;
    logic [AW-1:0] seen_addr;
    logic [DW-1:0] seen_wdata;

    // Compare process: check this cycle, then advance the model with this cycle's inputs.
    always @(negedge clk) begin
        if (cyc >= 1) begin
            chk("mem_req", mem_req, e_mem_req);
            chk("if_done", if_done, e_if_done);
            chk("d_done", d_done, e_d_done);
            chk("err", err, e_err);
            chk("if_stall", if_stall, if_req & ~e_if_done);
            chk("d_stall", d_stall, d_req & ~e_d_done);
            if (e_mem_req) begin
                chk("mem_we", mem_we, e_we);
                chk("mem_addr", mem_addr, e_addr);
                chk("mem_wdata", mem_wdata, e_wdata);
            end
            if (e_if_done) chk("if_rdata", if_rdata, e_if_rdata);
            if (e_d_done)  chk("d_rdata", d_rdata, e_d_rdata);
            if (mem_req && !prev_req) dut_log.push_back(mem_addr == 32'h200 ? "D" : "I");
            prev_req = mem_req;
            if (mem_req) req_high_cnt++;
            if (mem_req && !seen_valid) begin
                seen_valid = 1; seen_we = mem_we; seen_addr = mem_addr; seen_wdata = mem_wdata;
            end
        end
        if (reset) begin
            m_busy = 0; m_gap = 0; m_age = 0; m_burst = 0;
            e_mem_req = 0; e_we = 0; e_addr = '0; e_wdata = '0;
            e_if_done = 0; e_d_done = 0; e_err = 0; e_if_rdata = '0; e_d_rdata = '0;
        end else begin
            e_if_done = 0; e_d_done = 0; e_err = 0;
            if (m_gap) begin
                m_gap = 0;
            end else if (!m_busy) begin
                if (!if_req) m_burst = 0;
                if (d_req && (!if_req || m_burst < DBURST)) begin
                    if (if_req) m_burst = m_burst + 1;
                    m_busy = 1; m_owner_d = 1; m_age = 0;
                    e_mem_req = 1; e_we = d_we; e_addr = d_addr; e_wdata = d_wdata;
                    mdl_log.push_back("D");
                end else if (if_req) begin
                    m_burst = 0;
                    m_busy = 1; m_owner_d = 0; m_age = 0;
                    e_mem_req = 1; e_we = 0; e_addr = if_addr; e_wdata = '0;
                    mdl_log.push_back("I");
                end
            end else begin
                m_age = m_age + 1;
                if (mem_ack || m_age == TIMEOUT) begin
                    m_busy = 0; m_gap = 1; e_mem_req = 0;
                    m_rd = (mem_ack && !e_we) ? mem_rdata : '0;
                    e_err = !mem_ack;
                    if (m_owner_d) begin e_d_done = 1; e_d_rdata = m_rd; end
                    else           begin e_if_done = 1; e_if_rdata = m_rd; end
                end
            end
        end
    end

    // Driver: issue one request, wait (bounded) for its done pulse, then drop it.
    task automatic do_req(input bit is_d, input logic we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, output int n, output int done_cyc,
                          output logic [DW-1:0] rdata, output logic errv);
        @(posedge clk); #1;
        if (is_d) begin d_req = 1; d_we = we; d_addr = addr; d_wdata = wdata; end
        else      begin if_req = 1; if_addr = addr; end
        n = cyc; done_cyc = -1; rdata = '0; errv = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (is_d ? d_done : if_done) begin
                done_cyc = cyc; rdata = is_d ? d_rdata : if_rdata; errv = err;
                break;
            end
        end
        if (done_cyc < 0) chk("done_wait_expired", 0, 1);
        @(posedge clk); #1;
        d_req = 0; if_req = 0; d_we = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1, "watchdog");
    end

    int            n, dc, ndone;
    logic [DW-1:0] rd;
    logic          ev;
    string         exp_order;

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        chk("reset_mem_addr", mem_addr, 0);
        chk("reset_mem_wdata", mem_wdata, 0);
        chk("reset_if_rdata", if_rdata, 0);
        chk("reset_d_rdata", d_rdata, 0);
        chk("reset_mem_we", mem_we, 0);

        // Single load, ack one cycle after mem_req.
        ack_delay = 1; ack_data = 32'hDEADBEEF;
        do_req(1, 0, 32'h10, 0, n, dc, rd, ev);
        chk("load_latency", dc - n, 3);
        chk("load_rdata", rd, 32'hDEADBEEF);
        chk("load_err", ev, 0);

        // Store: fields on the bus, zero read data.
        ack_delay = 1; ack_data = 32'h5555AAAA; seen_valid = 0;
        do_req(1, 1, 32'h20, 32'h1234, n, dc, rd, ev);
        chk("store_mem_we", seen_we, 1);
        chk("store_mem_addr", seen_addr, 32'h20);
        chk("store_mem_wdata", seen_wdata, 32'h1234);
        chk("store_rdata", rd, 0);
        chk("store_latency", dc - n, 3);

        // Contention: both held; fetch gets every fifth grant.
        dut_log.delete(); mdl_log.delete();
        ack_delay = 1; ack_data = 32'h77;
        @(posedge clk); #1;
        if_req = 1; if_addr = 32'h100; d_req = 1; d_we = 0; d_addr = 32'h200; d_wdata = 0;
        ndone = 0;
        for (int k = 0; k < 200 && ndone < 10; k++) begin
            @(negedge clk);
            if (if_done || d_done) ndone++;
        end
        chk("burst_done_count", ndone, 10);
        @(posedge clk); #1; if_req = 0; d_req = 0;
        exp_order = "DDDDIDDDDI";
        chk("dut_grant_count", dut_log.size(), 10);
        chk("mdl_grant_count", mdl_log.size(), 10);
        for (int i = 0; i < 10; i++) begin
            if (i < dut_log.size()) chk($sformatf("dut_grant_%0d", i), dut_log[i], exp_order[i]);
            if (i < mdl_log.size()) chk($sformatf("mdl_grant_%0d", i), mdl_log[i], exp_order[i]);
        end

        // Timeout on a fetch: memory never acks.
        ack_delay = -1; req_high_cnt = 0;
        do_req(0, 0, 32'h40, 0, n, dc, rd, ev);
        chk("timeout_req_cycles", req_high_cnt, TIMEOUT);
        chk("timeout_latency", dc - n, TIMEOUT + 1);
        chk("timeout_err", ev, 1);
        chk("timeout_rdata", rd, 0);

        // Ack in the last allowed cycle counts as success.
        ack_delay = TIMEOUT - 1; ack_data = 32'hCAFEF00D;
        do_req(1, 0, 32'h50, 0, n, dc, rd, ev);
        chk("boundary_latency", dc - n, TIMEOUT + 1);
        chk("boundary_err", ev, 0);
        chk("boundary_rdata", rd, 32'hCAFEF00D);

        // Reset while busy on data, late ack afterwards.
        ack_delay = -1;
        @(posedge clk); #1; d_req = 1; d_we = 0; d_addr = 32'h30;
        @(posedge clk); #1;
        @(posedge clk); #1; reset = 1;
        @(posedge clk); #1; reset = 0; d_req = 0; force_ack = 1;
        @(negedge clk);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_d_done", d_done, 0);
        chk("rst_err", err, 0);
        chk("rst_mem_addr", mem_addr, 0);
        @(posedge clk); #1; force_ack = 0;
        @(negedge clk);
        chk("late_ack_d_done", d_done, 0);
        chk("late_ack_mem_req", mem_req, 0);

        // Fresh load after reset.
        ack_delay = 2; ack_data = 32'h0BADF00D;
        do_req(1, 0, 32'h60, 0, n, dc, rd, ev);
        chk("fresh_latency", dc - n, 4);
        chk("fresh_rdata", rd, 32'h0BADF00D);

        repeat (4) @(posedge clk);
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
